// File: rtl/ls_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller.
//   - access-type encodings and the signed-load bit position
//   - FSM state enum and the latched request record
//   - default IO region base and the type -> byte-count helper
package ls_mem_ctrl_pkg;

  localparam logic [1:0]  TYPE_WORD   = 2'b00;
  localparam logic [1:0]  TYPE_HALF   = 2'b01;
  localparam logic [1:0]  TYPE_BYTE   = 2'b10;
  localparam logic [1:0]  TYPE_INV    = 2'b11;
  localparam int          SIGN_BIT    = 2;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Request as captured at accept time; addr is kept separately at ADDR_W.
  typedef struct packed {
    logic [31:0] data;
    logic        r_nw;
    logic [2:0]  typ;
    logic [2:0]  n;
  } req_t;

  function automatic logic [2:0] byte_cnt(input logic [1:0] t);
    case (t)
      TYPE_WORD: return 3'd4;
      TYPE_HALF: return 3'd2;
      TYPE_BYTE: return 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ls_mem_ctrl_if.sv
// Request/response and RAM-port bundle of the load/store memory controller.
//   slave  : the controller (accepts requests, drives the RAM port)
//   master : the environment (load/store buffer + RAM/IO arbiter)
// Signals: activate_in, ls_addr, st_val, r_nw_in, type_in -> request
//          ld_val, ls_done                                -> response
//          mem_din, io_buffer_full                        -> RAM side in
//          mem_dout, mem_a, mem_wr                        -> RAM side out
interface ls_mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              activate_in;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       st_val;
  logic              r_nw_in;
  logic [2:0]        type_in;
  logic [31:0]       ld_val;
  logic              ls_done;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  activate_in, ls_addr, st_val, r_nw_in, type_in, mem_din, io_buffer_full,
    output ld_val, ls_done, mem_dout, mem_a, mem_wr
  );

  modport master (
    output activate_in, ls_addr, st_val, r_nw_in, type_in, mem_din, io_buffer_full,
    input  ld_val, ls_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/ls_extend.sv
// Load-result extension: selects word/half/byte from raw and sign- or
// zero-extends it. Shared with the instruction-fetch path.
//   raw : assembled little-endian bytes (unused upper lanes are don't-care)
//   typ : [1:0] access type, [2] signed
//   val : extended result (0 for the invalid type)
module ls_extend
  import ls_mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  typ,
  output logic [31:0] val
);
  logic sgn;
  assign sgn = typ[SIGN_BIT];

  always_comb begin
    val = '0;
    case (typ[1:0])
      TYPE_WORD: val = raw;
      TYPE_HALF: val = {{16{sgn & raw[15]}}, raw[15:0]};
      TYPE_BYTE: val = {{24{sgn & raw[7]}}, raw[7:0]};
      default:   val = '0;
    endcase
  end
endmodule

// File: rtl/ls_mem_ctrl.sv
// Memory-side responder for the load/store buffer. Serializes one load or
// store into byte transfers on the 8-bit RAM port and pulses ls_done.
//   clk_in, rst_in (async, active-low), rdy_in (0 = global pause)
//   bus : ls_mem_ctrl_if.slave (request, response and RAM port)
// mem_a/mem_dout are registered one transfer ahead so that the address for
// count c is on the port during the cycle cnt==c; RAM read data arrives one
// cycle later and is captured into lane c-1.
module ls_mem_ctrl
  import ls_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int          ADDR_W  = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  ls_mem_ctrl_if.slave bus
);
  state_t            state;
  req_t              req;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cnt;
  logic [31:0]       lanes;
  logic [31:0]       raw_nxt;
  logic [31:0]       ext_val;
  logic [2:0]        n_in;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        st_nxt;
  logic              io_stall;

  assign n_in     = byte_cnt(bus.type_in[1:0]);
  assign addr_nxt = addr_q + ADDR_W'(cnt) + ADDR_W'(1);
  assign io_stall = (state == BUSY) && !req.r_nw && bus.io_buffer_full &&
                    (addr_q >= IO_BASE[ADDR_W-1:0]);

  // Combinational so that reset, pause and IO stall all drop it at once.
  assign bus.mem_wr = (state == BUSY) && !req.r_nw && rdy_in && !io_stall;

  // Byte fetched for count cnt-1 merged into the lanes gathered so far.
  always_comb begin
    raw_nxt = lanes;
    case (cnt)
      3'd1:    raw_nxt[7:0]   = bus.mem_din;
      3'd2:    raw_nxt[15:8]  = bus.mem_din;
      3'd3:    raw_nxt[23:16] = bus.mem_din;
      3'd4:    raw_nxt[31:24] = bus.mem_din;
      default: raw_nxt = lanes;
    endcase
  end

  always_comb begin
    case (cnt)
      3'd0:    st_nxt = req.data[15:8];
      3'd1:    st_nxt = req.data[23:16];
      3'd2:    st_nxt = req.data[31:24];
      default: st_nxt = req.data[7:0];
    endcase
  end

  ls_extend u_ext (.raw(raw_nxt), .typ(req.typ), .val(ext_val));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      req          <= '0;
      addr_q       <= '0;
      cnt          <= '0;
      lanes        <= '0;
      bus.ld_val   <= '0;
      bus.ls_done  <= 1'b0;
      bus.mem_dout <= '0;
      bus.mem_a    <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (bus.activate_in) begin
            req    <= '{data: bus.st_val, r_nw: bus.r_nw_in, typ: bus.type_in, n: n_in};
            addr_q <= bus.ls_addr;
            cnt    <= '0;
            lanes  <= '0;
            if (n_in == 3'd0) begin
              bus.ld_val  <= '0;
              bus.ls_done <= 1'b1;
              state       <= DONE;
            end else begin
              bus.mem_a <= bus.ls_addr;
              if (!bus.r_nw_in) bus.mem_dout <= bus.st_val[7:0];
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (req.r_nw) begin
            lanes <= raw_nxt;
            if (cnt == req.n) begin
              bus.ld_val  <= ext_val;
              bus.ls_done <= 1'b1;
              state       <= DONE;
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt + 3'd1 < req.n) bus.mem_a <= addr_nxt;
            end
          end else if (!io_stall) begin
            if (cnt == req.n - 3'd1) begin
              bus.ls_done <= 1'b1;
              state       <= DONE;
            end else begin
              cnt          <= cnt + 3'd1;
              bus.mem_a    <= addr_nxt;
              bus.mem_dout <= st_nxt;
            end
          end
        end
        DONE: begin
          // activate_in is still high here; it is only looked at in IDLE.
          bus.ls_done <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
